// File: rtl/sequenciador_injecao.sv
// Fault-injection campaign sequencer: drives 16 Hamming(15,11) vectors through an
// injector/decoder pair and scores the corrected words. Optional timeout: SEQ_TIMEOUT_EN.
module sequenciador_injecao #(
  parameter int TIMEOUT_CICLOS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [14:0] palavra,
  output logic [14:0] inj_entrada,
  output logic [3:0]  inj_n,
  output logic        inj_erro,
  output logic        dec_req,
  input  logic        dec_ack,
  input  logic [14:0] dec_corrigida,
  output logic        busy,
  output logic        done,
  output logic [4:0]  acertos,
  output logic [4:0]  falhas,
  output logic        erro_timeout,
  output logic [1:0]  estado
);

  // dec_req/dec_ack: dec_req stays high in REQ until dec_ack is sampled high on a
  // rising edge; dec_corrigida is taken in that same cycle. dec_ack elsewhere is ignored.
  typedef enum logic [1:0] {IDLE, REQ, CHECK, DONE} estado_t;

  estado_t     estado_q, estado_d;
  logic [3:0]  idx_q;
  logic [14:0] palavra_q;
  logic [14:0] captura_q;
  logic [4:0]  acertos_q;
  logic [4:0]  falhas_q;
  logic        expira;
  logic        acerto;

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);

  logic [CW-1:0] cnt_q;
  logic          sem_captura_q;
  logic          timeout_q;

  assign expira = (estado_q == REQ) && !dec_ack && (cnt_q == CW'(TIMEOUT_CICLOS - 1));
  assign acerto = !sem_captura_q && (captura_q == palavra_q);
  assign erro_timeout = timeout_q;

  // Cleared outside REQ, so every REQ entry starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      sem_captura_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      if (estado_q == REQ) cnt_q <= cnt_q + CW'(1);
      else                 cnt_q <= '0;
      if (estado_q == IDLE && start) begin
        sem_captura_q <= 1'b0;
        timeout_q     <= 1'b0;
      end else if (expira) begin
        sem_captura_q <= 1'b1;
        timeout_q     <= 1'b1;
      end else if (estado_q == CHECK) begin
        sem_captura_q <= 1'b0;
      end
    end
  end
`else
  // Always false: the timeout path is compiled out and REQ waits indefinitely.
  assign expira = (TIMEOUT_CICLOS < 0);
  assign acerto = (captura_q == palavra_q);
  assign erro_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= IDLE;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE:    if (start) estado_d = REQ;
      REQ:     if (dec_ack || expira) estado_d = CHECK;
      CHECK:   estado_d = (idx_q == 4'd15) ? DONE : REQ;
      DONE:    estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      palavra_q <= '0;
      captura_q <= '0;
      acertos_q <= '0;
      falhas_q  <= '0;
    end else begin
      case (estado_q)
        IDLE: if (start) begin
          palavra_q <= palavra;
          acertos_q <= '0;
          falhas_q  <= '0;
          idx_q     <= '0;
        end
        REQ: if (dec_ack) captura_q <= dec_corrigida;
        CHECK: begin
          if (acerto) acertos_q <= acertos_q + 5'd1;
          else        falhas_q  <= falhas_q + 5'd1;
          if (idx_q != 4'd15) idx_q <= idx_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Vector 0 is the clean pass; vector k>0 flips bit k-1.
  assign inj_erro    = (estado_q != IDLE) && (idx_q != 4'd0);
  assign inj_n       = inj_erro ? (idx_q - 4'd1) : 4'd0;
  assign inj_entrada = palavra_q;
  assign dec_req     = (estado_q == REQ);
  assign busy        = (estado_q != IDLE);
  assign done        = (estado_q == DONE);
  assign acertos     = acertos_q;
  assign falhas      = falhas_q;
  assign estado      = estado_q;

endmodule

// File: tb/tb_sequenciador_injecao.sv
// Directed bench for sequenciador_injecao: decoder model, request scoreboard and
// campaign-level checks. Define SEQ_TIMEOUT_EN to add the timeout scenario.
`timescale 1ns/1ps
module tb_sequenciador_injecao;

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] palavra;
  logic [14:0] inj_entrada;
  logic [3:0]  inj_n;
  logic        inj_erro;
  logic        dec_req;
  logic        dec_ack;
  logic [14:0] dec_corrigida;
  logic        busy;
  logic        done;
  logic [4:0]  acertos;
  logic [4:0]  falhas;
  logic        erro_timeout;
  logic [1:0]  estado;

  int n_cmp = 0;
  int n_fail = 0;

  sequenciador_injecao #(.TIMEOUT_CICLOS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .palavra(palavra),
    .inj_entrada(inj_entrada), .inj_n(inj_n), .inj_erro(inj_erro),
    .dec_req(dec_req), .dec_ack(dec_ack), .dec_corrigida(dec_corrigida),
    .busy(busy), .done(done), .acertos(acertos), .falhas(falhas),
    .erro_timeout(erro_timeout), .estado(estado)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- decoder model ----------------
  logic [14:0] gold;
  int          ack_delay;
  int          corrupt_idx;
  int          noack_idx;
  logic        ack_model;
  logic        ack_extra;
  int          wc;
  int          vec_m;

  assign vec_m   = inj_erro ? (int'(inj_n) + 1) : 0;
  assign dec_ack = ack_model | ack_extra;
  assign dec_corrigida = ack_extra ? ~gold :
                         (gold ^ ((vec_m == corrupt_idx) ? 15'h0001 : 15'h0000));

  always @(negedge clk) begin
    if (!rst_n || !dec_req) begin
      ack_model = 1'b0;
      wc = 0;
    end else begin
      ack_model = (wc >= ack_delay) && (vec_m != noack_idx);
      wc++;
    end
  end

  // ---------------- scoreboard: one entry per expected request ----------------
  logic [27:0] exp_q[$];
  logic [27:0] ent;
  logic [19:0] cur;
  int          cur_len;
  int          req_cnt;
  logic        prev_req;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
      req_cnt  = 0;
    end else begin
      if (dec_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $error("FAIL req_inesperado observed=%0h expected=none", {inj_erro, inj_n, inj_entrada});
        end else begin
          ent     = exp_q.pop_front();
          cur     = ent[19:0];
          cur_len = int'(ent[27:20]);
          check("vetor", {12'd0, inj_erro, inj_n, inj_entrada}, {12'd0, cur});
        end
        req_cnt = 1;
      end else if (dec_req) begin
        check("inj_estavel", {12'd0, inj_erro, inj_n, inj_entrada}, {12'd0, cur});
        req_cnt++;
      end else if (prev_req) begin
        check("dur_req", req_cnt, cur_len);
      end
      prev_req = dec_req;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_inj_entrada"}, inj_entrada, 0);
    check({tag, "_inj"}, {inj_erro, inj_n}, 0);
    check({tag, "_req_busy_done"}, {dec_req, busy, done}, 0);
    check({tag, "_contadores"}, {erro_timeout, acertos, falhas}, 0);
    check({tag, "_estado"}, estado, 0);
  endtask

  // ---------------- one campaign ----------------
  task automatic run(input logic [14:0] p, input int delay, input int corrupt,
                     input int noack, input int rst_at, input int start_at,
                     input int extra_at, input int exp_cyc, input int exp_ac,
                     input int exp_fa, input logic exp_to);
    int cyc;
    int len;
    ack_delay   = delay;
    corrupt_idx = corrupt;
    noack_idx   = noack;
    for (int k = 0; k < 16; k++) begin
      len = (k == noack) ? TMO : delay + 1;
      exp_q.push_back({8'(len), (k != 0), (k == 0) ? 4'd0 : 4'(k - 1), p});
    end
    @(negedge clk);
    gold    = p;
    palavra = p;
    start   = 1'b1;
    cyc     = 1;
    while (1) begin
      @(negedge clk);
      cyc++;
      start     = 1'b0;
      ack_extra = 1'b0;
      if (cyc == start_at) begin
        start   = 1'b1;
        palavra = ~p;
      end
      if (cyc == extra_at) ack_extra = 1'b1;
      if (cyc == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset_meio");
        exp_q.delete();
        repeat (3) begin
          @(negedge clk);
          check("reset_sem_done", {done, busy}, 0);
        end
        #2 rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("pos_reset_idle", {done, busy}, 0);
        end
        return;
      end
      if (done) break;
      if (cyc > 400) begin
        n_cmp++;
        n_fail++;
        $error("FAIL espera_done observed=%0d expected=%0d", cyc, exp_cyc);
        break;
      end
    end
    check("ciclo_done", cyc, exp_cyc);
    @(negedge clk);
    check("done_um_ciclo", {done, busy}, 0);
    check("acertos", acertos, exp_ac);
    check("falhas", falhas, exp_fa);
    check("erro_timeout", erro_timeout, exp_to);
    check("vetores_restantes", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("contadores_mantidos", {erro_timeout, acertos, falhas}, {exp_to, 5'(exp_ac), 5'(exp_fa)});
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    palavra     = 15'h3C3C;
    gold        = 15'h0;
    ack_extra   = 1'b0;
    ack_delay   = 0;
    corrupt_idx = -1;
    noack_idx   = -1;
    #1 check_zero_outputs("reset_inicial");
    repeat (2) @(negedge clk);
    check("reset_sem_latch", inj_entrada, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_sem_start", {busy, dec_req}, 0);

    // Ideal decoder: done in cycle 34 counting the start cycle.
    run(15'h2AD5, 0, -1, -1, 0, 0, 0, 34, 16, 0, 1'b0);
    // Bad correction on vector 3 only.
    run(15'h5A3C, 0, 3, -1, 0, 0, 0, 34, 15, 1, 1'b0);
    // Ack 5 cycles late: 16 x (6 REQ + 1 CHECK) + 2.
    run(15'h2AD5, 5, -1, -1, 0, 0, 0, 114, 16, 0, 1'b0);
    // start during REQ (cycle 6) and stray ack during CHECK (cycle 9).
    run(15'h0F0F, 0, -1, -1, 0, 6, 9, 34, 16, 0, 1'b0);
    // Reset while vector 7 is requested, then a clean campaign.
    run(15'h2AD5, 0, -1, -1, 16, 0, 0, 34, 16, 0, 1'b0);
    run(15'h1234, 0, -1, -1, 0, 0, 0, 34, 16, 0, 1'b0);
`ifdef SEQ_TIMEOUT_EN
    // No ack on vector 2: 8 REQ cycles then scored as a failure.
    run(15'h2AD5, 0, -1, 2, 0, 0, 0, 41, 15, 1, 1'b1);
    run(15'h2AD5, 0, -1, -1, 0, 0, 0, 34, 16, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sequenciador_injecao.md
SEQUENCIADOR_INJECAO -- requirements
Module: sequenciador_injecao

Interface
REQ-001 Parameter TIMEOUT_CICLOS, default 64, sets the maximum cycles waited for dec_ack per vector; used only under REQ-025.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  launch a campaign; sampled only in IDLE.
REQ-005 palavra  input  15  golden Hamming(15,11) codeword; latched on accepted start.
REQ-006 inj_entrada  output  15  codeword driven to injector input.
REQ-007 inj_n  output  4  bit position driven to injector.
REQ-008 inj_erro  output  1  injector enable.
REQ-009 dec_req  output  1  request to decoder; held high until acknowledged.
REQ-010 dec_ack  input  1  decoder acknowledge; dec_corrigida is valid in the same cycle.
REQ-011 dec_corrigida  input  15  corrected codeword returned by the decoder.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at campaign end.
REQ-014 acertos  output  5  count of vectors where dec_corrigida equals the latched palavra (0..16).
REQ-015 falhas  output  5  count of mismatching or timed-out vectors (0..16).
REQ-016 erro_timeout  output  1  sticky timeout flag.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, REQ, CHECK and DONE.
REQ-018 In IDLE, start=1 SHALL do the following: latch palavra, clear acertos, falhas and erro_timeout, set vector index idx=0, and enter REQ on the next cycle.
REQ-019 The campaign SHALL have 16 vectors.
  - idx=0: inj_erro=0, inj_n=0 (clean pass).
  - idx=k (1..15): inj_erro=1, inj_n=k-1.
  - inj_entrada SHALL equal the latched palavra throughout.
REQ-020 In REQ, dec_req SHALL be 1; inj_entrada, inj_n and inj_erro SHALL be stable.
  - dec_ack=1 sampled: capture dec_corrigida, go to CHECK.
  - Otherwise: stay in REQ.
REQ-021 In CHECK, dec_req SHALL be 0.
  - Captured word equal to palavra: increment acertos; otherwise increment falhas.
  - idx=15: go to DONE.
  - Otherwise: increment idx and return to REQ.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle; next state is IDLE.
REQ-023 Counters and erro_timeout SHALL hold their final values in IDLE until the next accepted start.
  - acertos+falhas SHALL equal 16 after every completed campaign.
REQ-024 start SHALL be ignored outside IDLE.
  - dec_ack outside REQ SHALL be ignored.
  - With zero-wait ack, the campaign SHALL take 34 cycles from the start-accept edge to return to IDLE.
  - Breakdown: 16 vectors x (1 REQ + 1 CHECK) + 1 DONE + 1 return.

Configuration
REQ-025 Macro SEQ_TIMEOUT_EN.
  - Defined: a cycle counter SHALL run in REQ and reset on every REQ entry.
  - On reaching TIMEOUT_CICLOS without dec_ack, the FSM SHALL set erro_timeout, count the vector in falhas (no capture) and go to CHECK.
  - Undefined: REQ SHALL wait indefinitely; erro_timeout SHALL be tied to 0; no counter logic SHALL be present.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force the following.
  - State: IDLE; idx: 0.
  - Outputs: inj_entrada=0, inj_n=0, inj_erro=0, dec_req=0, busy=0, done=0, acertos=0, falhas=0, erro_timeout=0.
  - The latched palavra SHALL be cleared.
REQ-027 Reset asserted mid-campaign SHALL abort the campaign with no done pulse; operation resumes only on a new start after rst_n=1.

Verification
REQ-028 The bench SHALL cover the following directed scenarios.
  - Ideal decoder model (returns palavra, acks in the REQ cycle), palavra=15'h2AD5 -> 16 requests with inj_n sequence 0,0,1..14 and inj_erro 0,1x15, done pulse at cycle 34, acertos=16, falhas=0.
  - Model returns palavra^15'h0001 on idx=3 only -> acertos=15, falhas=1.
  - Ack delayed 5 cycles per vector -> dec_req high 6 cycles per vector, inj_* stable throughout, final acertos=16.
  - start pulsed during busy, and dec_ack pulsed while in CHECK -> no restart, no extra counts, totals unchanged.
  - rst_n low during idx=7 -> all outputs 0 at once, no done; a new start runs a full clean campaign.
  - SEQ_TIMEOUT_EN defined, TIMEOUT_CICLOS=8, no ack on idx=2 -> erro_timeout=1 after 8 REQ cycles, falhas=1, acertos=15, campaign completes.
